dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory (`dmem`, 48-bit words, synchronous write, combinational read) between the pipelined CPU's memory stage and an external requester (loader/DMA/debug). It grants one access per cycle and stalls the CPU pipeline when the CPU loses arbitration. A wait counter bounds how long the external requester can be starved. It sits between the `cpu` M-stage outputs (`MemWriteM`, `ALUOutM`, `WriteDataM`, `ReadDataM`) and `dmem`.

## Interface
- `SIZE`, 48, data and address width
- `MAX_WAIT`, 8, cycles an external request may wait before it is force-granted (≥1)

- `CLK`  in  1  single clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `CpuReq`  in  1  CPU M-stage access valid (load or store)
- `CpuWE`  in  1  CPU store
- `CpuAddr`  in  SIZE  CPU address (`ALUOutM`)
- `CpuWD`  in  SIZE  CPU store data (`WriteDataM`)
- `CpuRD`  out  SIZE  CPU load data (`ReadDataM`), combinational
- `CpuStall`  out  1  hold F/D/E/M pipeline registers
- `ExtReq`, `ExtWE`  in  1  external request, external write
- `ExtAddr`, `ExtWD`  in  SIZE  external address, write data
- `ExtGnt`  out  1  external access performed this cycle
- `ExtRD`  out  SIZE  external read data, registered
- `ExtRValid`  out  1  `ExtRD` valid pulse
- `MemWE`  out  1  to `dmem.WE`
- `MemA`, `MemWD`  out  SIZE  to `dmem.A`, `dmem.WD`
- `MemRD`  in  SIZE  from `dmem.RD`

## Operation
- Registered owner state `Owner`: `OWN_NONE`, `OWN_CPU`, `OWN_EXT`. It holds the owner of the previous cycle's access.
- The grant is combinational from `CpuReq`, `ExtReq`, `Owner` and `WaitCnt`:
  - Only one requester active: that requester wins.
  - Both active, `WaitCnt == MAX_WAIT`: Ext wins.
  - Both active, otherwise: CPU wins (default policy; see Configuration).
- Next `Owner` is the winner, or `OWN_NONE` when neither requests.
- Memory mux: the winner drives `MemA` and `MemWD`. `MemWE` = winner's WE. With no winner, `MemWE=0`, `MemA=0`, `MemWD=0`.
- `CpuRD` = `MemRD` when the CPU wins, else 0.
- `CpuStall` = `CpuReq & ~cpu_win`.
- `ExtGnt` = `ext_win`.
- `WaitCnt`, width `$clog2(MAX_WAIT+1)`:
  - Increments, saturating at `MAX_WAIT`, each cycle `ExtReq & ~ext_win`.
  - Clears on `ext_win` or when `ExtReq` is low.
- Ext handshake:
  - The requester holds `ExtReq`, `ExtWE`, `ExtAddr` and `ExtWD` stable until it samples `ExtGnt=1`.
  - The access completes in that cycle.
  - Keeping `ExtReq` high afterward presents the next request.
- Ext read: `ExtRD <= MemRD` and `ExtRValid <= 1` on the edge ending a granted read. Otherwise `ExtRValid <= 0` and `ExtRD` holds its value.

## Timing
- Grant, stall and mux paths: 0 cycles (combinational).
- CPU load data: same cycle as the grant. A stalled CPU access retries every cycle with unchanged inputs.
- Writes commit at the rising edge ending the granted cycle.
- Ext read latency: `ExtRValid` is high exactly 1 cycle after `ExtGnt`.
- Worst-case Ext wait: `MAX_WAIT` cycles under continuous CPU traffic. The grant occurs in wait cycle `MAX_WAIT+1`.
- Reset values (while `Reset=1`, overriding request inputs):
  - `Owner=OWN_NONE`, `WaitCnt=0`, `ExtRD=0`, `ExtRValid=0`.
  - Combinational outputs forced: `ExtGnt=0`, `CpuStall=0`, `MemWE=0`, `MemA=0`, `MemWD=0`, `CpuRD=0`.
- Reset mid-transaction: any pending Ext read is dropped (no `ExtRValid`). An Ext request still high after reset re-arbitrates from `WaitCnt=0`.
- Simultaneous arrival from `OWN_NONE`: CPU wins, unless `WaitCnt` is saturated.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: when both requesters are active and `WaitCnt < MAX_WAIT`, the winner is the opposite of `Owner`. When `Owner=OWN_NONE`, the CPU wins. The wait-counter override still applies.
- Not defined: fixed CPU priority with the starvation override only, as described in Operation.

## Structure
- Package `dmem_arb_pkg` holds:
  - `owner_t` enum (`OWN_NONE`, `OWN_CPU`, `OWN_EXT`), 2-bit.
  - `DMEM_ARB_SIZE_DEFAULT = 48`.
  - `DMEM_ARB_MAX_WAIT_DEFAULT = 8`.
- One sub-module, `arb_starve_cnt`: the saturating wait counter with `inc`, `clr` and `sat` ports, parameterised by `MAX_WAIT`.
- Grant logic, mux and Ext read register stay in `dmem_arbiter`.

## Test plan
- Reset held 2 cycles with both requests high → all outputs 0. After release, the CPU is granted in the first cycle.
- CPU-only store: `CpuAddr=0x10`, `CpuWD=0xABCD` → `MemWE=1`, `CpuStall=0`. A later CPU load from `0x10` returns `CpuRD=0xABCD` in the same cycle.
- Ext-only read of `0x10` → `ExtGnt=1` in the request cycle. Next cycle `ExtRValid=1`, `ExtRD=0xABCD`; the cycle after, `ExtRValid=0`.
- Continuous `CpuReq` and `ExtReq`, fixed priority, `MAX_WAIT=8` → `CpuStall=0` for 8 cycles. Cycle 9: `ExtGnt=1`, `CpuStall=1`, `WaitCnt` clears to 0.
- `DMEM_ARB_ROUND_ROBIN_EN` with both requesting continuously → grants alternate CPU, Ext, CPU, Ext. `CpuStall` is high every second cycle.
- Ext write granted and `Reset` asserted on the following cycle → the write persists in `dmem`, `ExtRValid` stays 0, and `WaitCnt=0` after reset.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   owner_t                   : owner of the previous cycle's memory access
//   DMEM_ARB_SIZE_DEFAULT     : default data/address width
//   DMEM_ARB_MAX_WAIT_DEFAULT : default external starvation bound in cycles
package dmem_arb_pkg;

  localparam int DMEM_ARB_SIZE_DEFAULT     = 48;
  localparam int DMEM_ARB_MAX_WAIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the CPU M-stage port, the external requester
// port and the dmem port seen by the arbiter.
//   slave  : arbiter view (requests and MemRD in; grants, data, mem controls out)
//   master : environment view (CPU, external requester and dmem together)
//
// Handshake: the external side raises ExtReq with ExtWE/ExtAddr/ExtWD and
// holds all four stable until it samples ExtGnt=1 at a rising edge; the access
// completes in that cycle, and ExtReq still high afterwards is a new request.
// A read's data appears on ExtRD with a one-cycle ExtRValid pulse in the cycle
// after the grant. The CPU side has no grant: CpuStall=1 means "not served,
// present the same access again next cycle".
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int SIZE = DMEM_ARB_SIZE_DEFAULT
);
  logic            CpuReq;
  logic            CpuWE;
  logic [SIZE-1:0] CpuAddr;
  logic [SIZE-1:0] CpuWD;
  logic [SIZE-1:0] CpuRD;
  logic            CpuStall;
  logic            ExtReq;
  logic            ExtWE;
  logic [SIZE-1:0] ExtAddr;
  logic [SIZE-1:0] ExtWD;
  logic            ExtGnt;
  logic [SIZE-1:0] ExtRD;
  logic            ExtRValid;
  logic            MemWE;
  logic [SIZE-1:0] MemA;
  logic [SIZE-1:0] MemWD;
  logic [SIZE-1:0] MemRD;

  modport slave (
    input  CpuReq, CpuWE, CpuAddr, CpuWD,
    input  ExtReq, ExtWE, ExtAddr, ExtWD,
    input  MemRD,
    output CpuRD, CpuStall,
    output ExtGnt, ExtRD, ExtRValid,
    output MemWE, MemA, MemWD
  );

  modport master (
    output CpuReq, CpuWE, CpuAddr, CpuWD,
    output ExtReq, ExtWE, ExtAddr, ExtWD,
    output MemRD,
    input  CpuRD, CpuStall,
    input  ExtGnt, ExtRD, ExtRValid,
    input  MemWE, MemA, MemWD
  );

endinterface

// File: rtl/dmem_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of cycles the external requester has
// waited without a grant.
//   clk, rst : clock, synchronous active-high reset
//   inc      : external request pending and not granted this cycle
//   clr      : request granted or withdrawn (wins over inc)
//   sat      : count has reached MAX_WAIT
//   cnt      : current count
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DEFAULT,
  localparam int CW      = $clog2(MAX_WAIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic          sat,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat = (cnt_q == CW'(MAX_WAIT));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU M-stage
// and an external requester, one access per cycle.
//   CLK, Reset   : clock, synchronous active-high reset
//   bus          : dmem_arbiter_if.slave (CPU port, external port, dmem port)
//   dbg_owner    : owner of the previous cycle's access
//   dbg_wait_cnt : external starvation counter
// Default policy is fixed CPU priority with a starvation override at MAX_WAIT.
// Defining DMEM_ARB_ROUND_ROBIN_EN makes contended grants alternate against
// the previous owner instead (override still applies).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int SIZE     = DMEM_ARB_SIZE_DEFAULT,
  parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT_DEFAULT,
  localparam int WCW     = $clog2(MAX_WAIT + 1)
) (
  input  logic                CLK,
  input  logic                Reset,
  dmem_arbiter_if.slave       bus,
  output owner_t              dbg_owner,
  output logic [WCW-1:0]      dbg_wait_cnt
);

  owner_t          owner_q, owner_d;
  logic [SIZE-1:0] ext_rd_q, ext_rd_d;
  logic            ext_rvalid_q, ext_rvalid_d;

  logic cpu_req, ext_req;
  logic cpu_win, ext_win;
  logic wait_sat;
  logic wait_inc, wait_clr;

  // Reset masks both requests so every combinational output falls to zero.
  assign cpu_req = bus.CpuReq & ~Reset;
  assign ext_req = bus.ExtReq & ~Reset;

  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (cpu_req && ext_req) begin
      if (wait_sat) begin
        ext_win = 1'b1;
      end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // Alternate against the last owner; no history means CPU first.
        if (owner_q == OWN_CPU) begin
          ext_win = 1'b1;
        end else begin
          cpu_win = 1'b1;
        end
`else
        cpu_win = 1'b1;
`endif
      end
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end else if (ext_req) begin
      ext_win = 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_win) begin
      owner_d = OWN_CPU;
    end else if (ext_win) begin
      owner_d = OWN_EXT;
    end
  end

  // Memory mux and CPU-side results.
  always_comb begin
    bus.MemWE = 1'b0;
    bus.MemA  = '0;
    bus.MemWD = '0;
    bus.CpuRD = '0;
    if (cpu_win) begin
      bus.MemWE = bus.CpuWE;
      bus.MemA  = bus.CpuAddr;
      bus.MemWD = bus.CpuWD;
      bus.CpuRD = bus.MemRD;
    end else if (ext_win) begin
      bus.MemWE = bus.ExtWE;
      bus.MemA  = bus.ExtAddr;
      bus.MemWD = bus.ExtWD;
    end
  end

  assign bus.CpuStall = cpu_req & ~cpu_win;
  assign bus.ExtGnt   = ext_win;

  // External read data is captured on the edge that ends the granted read.
  always_comb begin
    ext_rvalid_d = ext_win & ~bus.ExtWE;
    ext_rd_d     = ext_rvalid_d ? bus.MemRD : ext_rd_q;
  end

  assign wait_inc = ext_req & ~ext_win;
  assign wait_clr = ext_win | ~ext_req;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk (CLK),
    .rst (Reset),
    .inc (wait_inc),
    .clr (wait_clr),
    .sat (wait_sat),
    .cnt (dbg_wait_cnt)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      owner_q      <= OWN_NONE;
      ext_rd_q     <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      ext_rd_q     <= ext_rd_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  assign bus.ExtRD     = ext_rd_q;
  assign bus.ExtRValid = ext_rvalid_q;
  assign dbg_owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int SIZE     = 48;
  localparam int MAX_WAIT = 8;
  localparam int WCW      = $clog2(MAX_WAIT + 1);
  localparam int DEPTH    = 64;

  typedef struct packed {
    logic            ext_gnt;
    logic            cpu_stall;
    logic            mem_we;
    logic [SIZE-1:0] mem_a;
    logic [SIZE-1:0] mem_wd;
    logic [SIZE-1:0] cpu_rd;
    logic            ext_rvalid;
    logic [SIZE-1:0] ext_rd;
    logic [WCW-1:0]  wait_cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.SIZE(SIZE)) bus ();
  owner_t         dbg_owner;
  logic [WCW-1:0] dbg_wait_cnt;

  dmem_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .bus          (bus),
    .dbg_owner    (dbg_owner),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // ---------------- dmem attached to the DUT ----------------
  logic [SIZE-1:0] dmem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) dmem[i] = '0;
  always @(posedge CLK) if (bus.MemWE) dmem[bus.MemA[5:0]] <= bus.MemWD;
  assign bus.MemRD = dmem[bus.MemA[5:0]];

  // ---------------- reference model ----------------
  logic [SIZE-1:0] ref_mem [DEPTH];
  int              m_wait;     // cycles the current ext request has waited
  int              m_last;     // 0 none, 1 cpu, 2 ext
  logic            m_rvalid;
  logic [SIZE-1:0] m_rd;
  logic            m_cw, m_ew; // winners of the most recent driven cycle

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- driver ----------------
  task automatic drive(input logic chk, input logic rst,
                       input logic creq, input logic cwe,
                       input logic [SIZE-1:0] caddr, input logic [SIZE-1:0] cwd,
                       input logic ereq, input logic ewe,
                       input logic [SIZE-1:0] eaddr, input logic [SIZE-1:0] ewd);
    exp_t e;
    logic cw, ew;
    @(posedge CLK);
    #1;
    Reset       = rst;
    bus.CpuReq  = creq;  bus.CpuWE = cwe;  bus.CpuAddr = caddr; bus.CpuWD = cwd;
    bus.ExtReq  = ereq;  bus.ExtWE = ewe;  bus.ExtAddr = eaddr; bus.ExtWD = ewd;

    e            = '0;
    e.ext_rvalid = m_rvalid;
    e.ext_rd     = m_rd;
    e.wait_cnt   = WCW'(m_wait);
    cw = 1'b0;
    ew = 1'b0;
    if (rst) begin
      m_wait = 0; m_last = 0; m_rvalid = 1'b0; m_rd = '0;
    end else begin
      if (creq && ereq) begin
        if (m_wait == MAX_WAIT) ew = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        else if (m_last == 1) ew = 1'b1;
`endif
        else cw = 1'b1;
      end else begin
        cw = creq;
        ew = ereq;
      end
      e.ext_gnt   = ew;
      e.cpu_stall = creq & ~cw;
      if (cw) begin
        e.mem_we = cwe; e.mem_a = caddr; e.mem_wd = cwd;
        e.cpu_rd = ref_mem[caddr[5:0]];
      end else if (ew) begin
        e.mem_we = ewe; e.mem_a = eaddr; e.mem_wd = ewd;
      end
      m_rvalid = ew & ~ewe;
      if (m_rvalid) m_rd = ref_mem[eaddr[5:0]];
      if (cw && cwe) ref_mem[caddr[5:0]] = cwd;
      if (ew && ewe) ref_mem[eaddr[5:0]] = ewd;
      if (ereq && !ew) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      m_last = cw ? 1 : (ew ? 2 : 0);
    end
    m_cw = cw;
    m_ew = ew;
    if (chk) exp_q.push_back(EW'(e));
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic cmp(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        cmp("ExtGnt",    SIZE'(bus.ExtGnt),    SIZE'(e.ext_gnt));
        cmp("CpuStall",  SIZE'(bus.CpuStall),  SIZE'(e.cpu_stall));
        cmp("MemWE",     SIZE'(bus.MemWE),     SIZE'(e.mem_we));
        cmp("MemA",      bus.MemA,             e.mem_a);
        cmp("MemWD",     bus.MemWD,            e.mem_wd);
        cmp("CpuRD",     bus.CpuRD,            e.cpu_rd);
        cmp("ExtRValid", SIZE'(bus.ExtRValid), SIZE'(e.ext_rvalid));
        cmp("ExtRD",     bus.ExtRD,            e.ext_rd);
        cmp("WaitCnt",   SIZE'(dbg_wait_cnt),  SIZE'(e.wait_cnt));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic            c_req, c_we, e_req, e_we, rst;
    logic [SIZE-1:0] c_addr, c_wd, e_addr, e_wd;
    logic            e_pending, c_pending;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_wait = 0; m_last = 0; m_rvalid = 1'b0; m_rd = '0;
    bus.CpuReq = 1'b0; bus.CpuWE = 1'b0; bus.CpuAddr = '0; bus.CpuWD = '0;
    bus.ExtReq = 1'b0; bus.ExtWE = 1'b0; bus.ExtAddr = '0; bus.ExtWD = '0;

    // Reset held 2 cycles with both requests high; registered outputs are
    // only defined after the first reset edge.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 48'h3, '0, 1'b1, 1'b0, 48'h4, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 48'h3, '0, 1'b1, 1'b0, 48'h4, '0);
    // First cycle after release: CPU wins the contended access.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 48'h3, '0, 1'b1, 1'b0, 48'h4, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h4, '0);
    idle();

    // CPU store then load of 0x10.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 48'h10, 48'hABCD, 1'b0, 1'b0, '0, '0);
    idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 48'h10, '0, 1'b0, 1'b0, '0, '0);

    // External read of 0x10, then two idle cycles for the rvalid pulse.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h10, '0);
    idle();
    idle();

    // Continuous contention: starvation override in cycle MAX_WAIT+1.
    for (int i = 0; i < 2 * (MAX_WAIT + 1) + 2; i++)
      drive(1'b1, 1'b0, 1'b1, 1'b0, 48'h10, '0, 1'b1, 1'b0, 48'h10, '0);
    idle();

    // External write granted, reset next cycle, then read it back.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 48'h5, 48'h5A5A_1234);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 48'h5, 48'h5A5A_1234);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h5, '0);
    idle();
    // External read granted with reset the next cycle: pulse already issued.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    // External read granted in the same cycle reset rises: no access at all.
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 48'h10, '0);
    idle();

    // Randomised traffic obeying the hold-until-served rules.
    e_pending = 1'b0; c_pending = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!c_pending) begin
        c_req  = ($urandom_range(0, 99) < 70);
        c_we   = $urandom_range(0, 1);
        c_addr = SIZE'($urandom_range(0, DEPTH - 1));
        c_wd   = {16'($urandom), 32'($urandom)};
      end
      if (!e_pending) begin
        e_req  = ($urandom_range(0, 99) < 50);
        e_we   = $urandom_range(0, 1);
        e_addr = SIZE'($urandom_range(0, DEPTH - 1));
        e_wd   = {16'($urandom), 32'($urandom)};
      end
      rst = ($urandom_range(0, 59) == 0);
      drive(1'b1, rst, c_req, c_we, c_addr, c_wd, e_req, e_we, e_addr, e_wd);
      c_pending = c_req & ~m_cw & ~rst;
      e_pending = e_req & ~m_ew;
    end
    idle();

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
